// File: rtl/nest_checker.sv
// nest_checker: streaming begin/end and fork/join nesting checker.
// One ASCII byte per valid cycle; outputs decode registered state only.
module nest_checker #(
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in,
  input  logic          valid,
  output logic          result,
  output logic          error,
  output logic          overflow,
  output logic [DW-1:0] depth
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int SW   = 1 << CW;
  localparam int DMAX = (1 << DW) - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MATCH = 3'd1,
    S_DONE  = 3'd2,
    S_JUNK  = 3'd3,
    S_DEAD  = 3'd4
  } state_t;

  // keyword ids: bit1 = nesting type, bit0 = close
  localparam logic [1:0] KW_BEGIN = 2'd0;
  localparam logic [1:0] KW_END   = 2'd1;
  localparam logic [1:0] KW_FORK  = 2'd2;
  localparam logic [1:0] KW_JOIN  = 2'd3;

  state_t        st_q, st_d;
  logic [1:0]    kw_q, kw_d;
  logic [2:0]    pos_q, pos_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stk_q, stk_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;

  logic [7:0]    lc;
  logic          sp;
  logic [CW-1:0] top_idx;
  logic          top;
  logic          empty;
  logic          full;
  logic          ktype;
  logic          kclose;
  logic          bad_close;
  logic          tent_bad;
  int            eff;

  function automatic logic [7:0] kw_char(
    input logic [1:0] kw,
    input logic [2:0] pos
  );
    logic [39:0] s;
    int          p;
    unique case (kw)
      KW_BEGIN: s = "begin";
      KW_END:   s = {"end", 16'h0};
      KW_FORK:  s = {"fork", 8'h0};
      default:  s = {"join", 8'h0};
    endcase
    p = int'(pos);
    if (p > 4) return 8'h00;
    return s[8*(4-p) +: 8];
  endfunction

  function automatic logic [2:0] kw_len(input logic [1:0] kw);
    unique case (kw)
      KW_BEGIN: return 3'd5;
      KW_END:   return 3'd3;
      default:  return 3'd4;
    endcase
  endfunction

  // Character classification and stack top view
  always_comb begin
    lc = in;
    if (in >= 8'h41 && in <= 8'h5a) lc = in | 8'h20;
    sp        = (in == 8'h20);
    top_idx   = cnt_q - CW'(1);
    top       = stk_q[top_idx];
    empty     = (cnt_q == '0);
    full      = (cnt_q == CW'(DEPTH));
    ktype     = kw_q[1];
    kclose    = kw_q[0];
    bad_close = empty || (top != ktype);
  end

  // Tokenizer FSM and stack commit
  always_comb begin
    st_d  = st_q;
    kw_d  = kw_q;
    pos_d = pos_q;
    cnt_d = cnt_q;
    stk_d = stk_q;
    err_d = err_q;
    ovf_d = ovf_q;
    unique case (st_q)
      S_IDLE: begin
        if (valid && !sp) begin
          st_d  = S_MATCH;
          pos_d = 3'd1;
          unique case (1'b1)
            (lc == "b"): kw_d = KW_BEGIN;
            (lc == "e"): kw_d = KW_END;
            (lc == "f"): kw_d = KW_FORK;
            (lc == "j"): kw_d = KW_JOIN;
            default:     st_d = S_JUNK;
          endcase
        end
      end
      S_MATCH: begin
        if (valid) begin
          if (sp) begin
            st_d = S_IDLE;
          end else if (lc == kw_char(kw_q, pos_q)) begin
            pos_d = pos_q + 3'd1;
            if (pos_q + 3'd1 == kw_len(kw_q)) st_d = S_DONE;
          end else begin
            st_d = S_JUNK;
          end
        end
      end
      S_DONE: begin
        if (valid) begin
          if (!sp) begin
            st_d = S_JUNK;
          end else if (kclose) begin
            if (bad_close) begin
              err_d = 1'b1;
              st_d  = S_DEAD;
            end else begin
              cnt_d = cnt_q - CW'(1);
              st_d  = S_IDLE;
            end
          end else if (full) begin
            ovf_d = 1'b1;
            err_d = 1'b1;
            st_d  = S_DEAD;
          end else begin
            stk_d[cnt_q] = ktype;
            cnt_d        = cnt_q + CW'(1);
            st_d         = S_IDLE;
          end
        end
      end
      S_JUNK: begin
        if (valid && sp) st_d = S_IDLE;
      end
      S_DEAD: begin
        st_d = S_DEAD;
      end
      default: begin
        st_d = S_DEAD;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= S_IDLE;
      kw_q  <= '0;
      pos_q <= '0;
      cnt_q <= '0;
      stk_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      kw_q  <= kw_d;
      pos_q <= pos_d;
      cnt_q <= cnt_d;
      stk_q <= stk_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end

  // Effective depth counts a completed keyword as if the stream ended now
  always_comb begin
    eff      = int'(cnt_q);
    tent_bad = 1'b0;
    if (st_q == S_DONE) begin
      if (kclose) begin
        tent_bad = bad_close;
        eff      = empty ? 0 : eff - 1;
      end else begin
        eff = eff + 1;
      end
    end
    result   = (st_q != S_DEAD) && (eff == 0) && !tent_bad;
    error    = err_q;
    overflow = ovf_q;
    depth    = (eff > DMAX) ? DW'(DMAX) : DW'(eff);
  end

endmodule

// File: tb/tb_nest_checker.sv
// tb_nest_checker: directed stimulus with queued expectations
// checked by a negedge monitor on two DUT instances.
module tb_nest_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       vin = 1'b0;

  logic       res1, err1, ovf1;
  logic [3:0] dep1;
  logic       res2, err2, ovf2;
  logic [1:0] dep2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int         tgt;
    logic       inst;
    logic [6:0] exp;
  } ent_t;

  ent_t  q[$];
  string nq[$];

  nest_checker #(.DEPTH(8), .DW(4)) u_dut (
    .clk      (clk),
    .reset    (rst_n),
    .in       (din),
    .valid    (vin),
    .result   (res1),
    .error    (err1),
    .overflow (ovf1),
    .depth    (dep1)
  );

  nest_checker #(.DEPTH(2), .DW(2)) u_dut2 (
    .clk      (clk),
    .reset    (rst_n),
    .in       (din),
    .valid    (vin),
    .result   (res2),
    .error    (err2),
    .overflow (ovf2),
    .depth    (dep2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ent_t       e;
    string      n;
    logic [6:0] got;
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      e = q.pop_front();
      n = nq.pop_front();
      got = e.inst ? {res2, err2, ovf2, 2'b00, dep2}
                   : {res1, err1, ovf1, dep1};
      checks++;
      if (e.tgt != cyc) begin
        errors++;
        $display("FAIL %s: checked late at cycle %0d, due %0d",
                 n, cyc, e.tgt);
      end else if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got r=%b e=%b o=%b d=%0d want r=%b e=%b o=%b d=%0d",
                 n, got[6], got[5], got[4], got[3:0],
                 e.exp[6], e.exp[5], e.exp[4], e.exp[3:0]);
      end
    end
  end

  task automatic chk(input string nm, input logic r, input logic e,
                     input logic o, input logic [3:0] d,
                     input int dly = 1, input logic inst = 1'b0);
    ent_t x;
    x.tgt  = cyc + dly;
    x.inst = inst;
    x.exp  = {r, e, o, d};
    q.push_back(x);
    nq.push_back(nm);
  endtask

  task automatic send(input string s, input logic v = 1'b1);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      din = s[i];
      vin = v;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    vin = 1'b0;
    din = 8'h00;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    vin = 1'b0;
    din = 8'h00;
    @(posedge clk);
    #2 rst_n = 1'b0;
    chk(nm, 1, 0, 0, 0, 0, 1'b0);
    chk(nm, 1, 0, 0, 0, 0, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    do_reset("reset_init");

    send("BEGIN");  chk("a_begin", 0, 0, 0, 1);
    send(" fork");  chk("a_fork", 0, 0, 0, 2);
    send(" join");  chk("a_join", 0, 0, 0, 1);
    send(" End");   chk("a_end", 1, 0, 0, 0);
    send(" ");      chk("a_commit", 1, 0, 0, 0);

    do_reset("reset_b");
    send("begin join"); chk("b_tent_mis", 0, 0, 0, 0);
    send(" ");          chk("b_dead", 0, 1, 0, 1);
    send("end ");       chk("b_frozen", 0, 1, 0, 1);

    do_reset("reset_dead");
    send("begin");  chk("c_begin", 0, 0, 0, 1);
    send(" ");      chk("c_space", 0, 0, 0, 1);
    send("end");    chk("c_end", 1, 0, 0, 0);
    send("i");      chk("c_endi", 0, 0, 0, 1);
    send("ng ");    chk("c_ending", 0, 0, 0, 1);

    do_reset("reset_d");
    send("begin begin begin");
    chk("d_tent3", 0, 0, 0, 3, 1, 1'b1);
    send(" ");
    chk("d_ovf", 0, 1, 1, 2, 1, 1'b1);

    do_reset("reset_e");
    send("b");         chk("e_b", 1, 0, 0, 0);
    send("x", 1'b0);   chk("e_hold", 1, 0, 0, 0);
    send("e");
    send("x", 1'b0);
    send("g");
    send("x", 1'b0);
    send("i");
    send("x", 1'b0);
    send("n");         chk("e_n", 0, 0, 0, 1);
    send("x", 1'b0);   chk("e_hold2", 0, 0, 0, 1);
    send(" ");         chk("e_commit", 0, 0, 0, 1);
    send("end ");      chk("e_close", 1, 0, 0, 0);

    do_reset("reset_f");
    send("begin fo");  chk("f_prefix", 0, 0, 0, 1);
    do_reset("f_midtok");
    send("end");       chk("f_tent_under", 0, 0, 0, 0);
    send(" ");         chk("f_under", 0, 1, 0, 0);

    do_reset("reset_g");
    send("  xbegin forks");  chk("g_junk", 1, 0, 0, 0);
    send(" FORK  ");         chk("g_fork", 0, 0, 0, 1);
    send("JoIn ");           chk("g_join", 1, 0, 0, 0);
    idle();

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never checked, want 0",
               q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
